program_loader: RTL and testbench

//   Byte-stream boot loader upstream of cpu_top. Receives framed program images,

---
 rtl/program_loader.sv | 113 +++++++++++
 tb/tb_program_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: parses framed byte-stream images into the memory write port and
// holds the CPU in reset until a clean image has been loaded.
module program_loader #(
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter logic [7:0]  END_BYTE = 8'h5A,
    parameter logic [15:0] ROM_TOP  = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_rom_sel,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {
        StIdle, StAhi, StAlo, StLen, StData, StCsum, StDone, StFail
    } state_t;

    state_t      state_q;
    logic [15:0] addr_q;
    logic [8:0]  cnt_q;
    logic [7:0]  sum_q;
    logic [7:0]  sum_next;
    logic        xfer;

    assign rx_ready = (state_q != StDone) && (state_q != StFail);
    assign xfer     = rx_valid && rx_ready;
    assign sum_next = sum_q + rx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= 16'h0000;
            cnt_q       <= 9'd0;
            sum_q       <= 8'h00;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
            mem_rom_sel <= 1'b0;
            cpu_reset   <= 1'b1;
            load_done   <= 1'b0;
            err         <= 1'b0;
            frame_cnt   <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_data == HDR_BYTE) begin
                            state_q <= StAhi;
                        end else if (rx_data == END_BYTE) begin
                            if (err) begin
                                state_q <= StFail;
                            end else begin
                                state_q   <= StDone;
                                cpu_reset <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end
                    end
                    StAhi: begin
                        addr_q[15:8] <= rx_data;
                        sum_q        <= rx_data;
                        state_q      <= StAlo;
                    end
                    StAlo: begin
                        addr_q[7:0] <= rx_data;
                        sum_q       <= sum_next;
                        state_q     <= StLen;
                    end
                    StLen: begin
                        // A zero length byte encodes a full 256-byte payload.
                        cnt_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        sum_q   <= sum_next;
                        state_q <= StData;
                    end
                    StData: begin
                        mem_addr    <= addr_q;
                        mem_wdata   <= rx_data;
                        mem_we      <= 1'b1;
                        mem_rom_sel <= (addr_q < ROM_TOP);
                        addr_q      <= addr_q + 16'h0001;
                        cnt_q       <= cnt_q - 9'd1;
                        sum_q       <= sum_next;
                        if (cnt_q == 9'd1) begin
                            state_q <= StCsum;
                        end
                    end
                    StCsum: begin
                        if (sum_next == 8'h00) begin
                            if (frame_cnt != 8'hFF) begin
                                frame_cnt <= frame_cnt + 8'h01;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    StDone, StFail: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: frames, checksum errors,
// address wrap, 256-byte payloads, idle garbage, rx_valid gaps and mid-frame reset.
module tb_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_rom_sel;
    logic        cpu_reset;
    logic        load_done;
    logic        err;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic        ws[$];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rom_sel(mem_rom_sel),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .err        (err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Write log sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            ws.push_back(mem_rom_sel);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        ws.delete();
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_log();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t s, input int gap);
        foreach (s[i]) begin
            send(s[i]);
            for (int g = 0; g < gap; g++) begin
                rx_data = 8'hA5;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [15:0] a,
                               input logic [7:0] d, input logic s);
        if (idx < wa.size()) begin
            check({tag, " addr"}, {16'h0, wa[idx]}, {16'h0, a});
            check({tag, " data"}, {24'h0, wd[idx]}, {24'h0, d});
            check({tag, " rom_sel"}, {31'h0, ws[idx]}, {31'h0, s});
        end else begin
            check({tag, " missing"}, wa.size(), idx + 1);
        end
    endtask

    initial begin
        byte_q_t f;
        int bad;

        // Reset state
        do_reset();
        check("rst rx_ready", rx_ready, 1);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst cpu_reset", cpu_reset, 1);
        check("rst load_done", load_done, 0);
        check("rst err", err, 0);
        check("rst frame_cnt", frame_cnt, 0);

        // 1: good frame then END
        f = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'hA9, 8'h55, 8'h00};
        send_seq(f, 0);
        settle();
        check("t1 nwrites", wa.size(), 2);
        check_write("t1 w0", 0, 16'h0000, 8'hA9, 1'b1);
        check_write("t1 w1", 1, 16'h0001, 8'h55, 1'b1);
        check("t1 frame_cnt", frame_cnt, 1);
        check("t1 err", err, 0);
        check("t1 cpu_reset before end", cpu_reset, 1);
        send(8'h5A);
        check("t1 cpu_reset", cpu_reset, 0);
        check("t1 load_done", load_done, 1);
        check("t1 rx_ready done", rx_ready, 0);

        // 2: bad checksum then END -> FAIL
        do_reset();
        f = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'hA9, 8'h55, 8'h01};
        send_seq(f, 0);
        settle();
        check("t2 nwrites", wa.size(), 2);
        check_write("t2 w0", 0, 16'h0000, 8'hA9, 1'b1);
        check_write("t2 w1", 1, 16'h0001, 8'h55, 1'b1);
        check("t2 err", err, 1);
        check("t2 frame_cnt", frame_cnt, 0);
        send(8'h5A);
        settle();
        check("t2 cpu_reset", cpu_reset, 1);
        check("t2 load_done", load_done, 0);
        check("t2 rx_ready fail", rx_ready, 0);
        check("t2 err sticky", err, 1);

        // 3: address wrap FFFF -> 0000
        do_reset();
        f = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
        send_seq(f, 0);
        settle();
        check("t3 nwrites", wa.size(), 2);
        check_write("t3 w0", 0, 16'hFFFF, 8'h11, 1'b0);
        check_write("t3 w1", 1, 16'h0000, 8'h22, 1'b1);
        check("t3 err", err, 0);
        check("t3 frame_cnt", frame_cnt, 1);

        // 4: LEN=0 -> 256-byte payload at 0100
        do_reset();
        f = '{8'hA5, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) f.push_back(i[7:0]);
        f.push_back(8'h7F);
        send_seq(f, 0);
        settle();
        check("t4 nwrites", wa.size(), 256);
        bad = 0;
        for (int i = 0; i < wa.size() && i < 256; i++) begin
            if (wa[i] !== 16'h0100 + i[15:0] || wd[i] !== i[7:0] || ws[i] !== 1'b0) bad++;
        end
        check("t4 payload errors", bad, 0);
        check("t4 frame_cnt", frame_cnt, 1);
        check("t4 err", err, 0);
        send(8'h5A);
        check("t4 load_done", load_done, 1);

        // 5: idle garbage, then frame with rx_valid gaps
        do_reset();
        f = '{8'h33, 8'h44};
        send_seq(f, 0);
        f = '{8'hA5, 8'h00, 8'h10, 8'h01, 8'h77, 8'h78};
        send_seq(f, 2);
        settle();
        check("t5 nwrites", wa.size(), 1);
        check_write("t5 w0", 0, 16'h0010, 8'h77, 1'b1);
        check("t5 frame_cnt", frame_cnt, 1);
        check("t5 err", err, 0);

        // 6: reset after 1 of 4 data bytes
        do_reset();
        f = '{8'hA5, 8'h02, 8'h00, 8'h04, 8'h11};
        send_seq(f, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6 mem_we async clear", mem_we, 0);
        check("t6 cpu_reset", cpu_reset, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        check("t6 nwrites before reset", wa.size(), 1);
        check_write("t6 w0", 0, 16'h0200, 8'h11, 1'b0);
        clear_log();
        f = '{8'h22, 8'h33, 8'h44};
        send_seq(f, 0);
        settle();
        check("t6 no writes from leftovers", wa.size(), 0);
        f = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h99, 8'h46};
        send_seq(f, 0);
        settle();
        check("t6 nwrites after", wa.size(), 1);
        check_write("t6 w1", 0, 16'h0020, 8'h99, 1'b1);
        check("t6 frame_cnt", frame_cnt, 1);
        check("t6 err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
